// File: rtl/mem_access_ctrl_if.sv
// Interface bundling the execute-stage request, the write-back results and
// the data-side bus port of mem_access_ctrl.
//   master : the controller side (mem_access_ctrl)
//   slave  : the surrounding pipeline / memory side
interface mem_access_ctrl_if;
    // Execute-stage request
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Pipeline / write-back results
    logic        mem_stall;
    logic [31:0] read_data;
    logic        read_valid;
    logic [31:0] wb_mask;
    logic        fault;
    // Data-side bus
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_stall, read_data, read_valid, wb_mask, fault,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_stall, read_data, read_valid, wb_mask, fault,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences execute-stage loads/stores onto a single-
// outstanding data bus. Stalls the pipeline for the access, steers store
// byte lanes/strobes, aligns and extends load data, and flags misaligned
// or illegal-size accesses.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a bus access
// that has not been acknowledged within TIMEOUT_CYCLES cycles. Without the
// macro the controller waits in BUS indefinitely.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.master mif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q;

    // Latched request attributes needed after IDLE
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;

    // Registered outputs
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] read_data_q;
    logic        read_valid_q;
    logic [31:0] wb_mask_q;
    logic        fault_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  tmo_cnt_q;
`endif

    // Next-value helpers derived from the incoming request / bus data
    logic        misaligned_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic [31:0] shifted_d;
    logic [31:0] rdata_d;
    logic [31:0] mask_d;

    // Classify the incoming request: illegal size or misaligned address
    always_comb begin
        misaligned_d = 1'b0;
        case (mif.req_size)
            SZ_BYTE: misaligned_d = 1'b0;
            SZ_HALF: misaligned_d = mif.req_addr[0];
            SZ_WORD: misaligned_d = (mif.req_addr[1:0] != 2'b00);
            default: misaligned_d = 1'b1;
        endcase
    end

    // Store lane replication and byte strobes; loads never assert strobes
    always_comb begin
        wdata_d = mif.req_wdata;
        wstrb_d = 4'b0000;
        if (mif.req_we) begin
            case (mif.req_size)
                SZ_BYTE: begin
                    wdata_d = {4{mif.req_wdata[7:0]}};
                    wstrb_d = 4'b0001 << mif.req_addr[1:0];
                end
                SZ_HALF: begin
                    wdata_d = {2{mif.req_wdata[15:0]}};
                    wstrb_d = 4'b0011 << mif.req_addr[1:0];
                end
                SZ_WORD: begin
                    wdata_d = mif.req_wdata;
                    wstrb_d = 4'b1111;
                end
                default: begin
                    wdata_d = mif.req_wdata;
                    wstrb_d = 4'b0000;
                end
            endcase
        end else begin
            wdata_d = mif.req_wdata;
            wstrb_d = 4'b0000;
        end
    end

    // Load alignment: shift the addressed lane down, then sign/zero extend
    always_comb begin
        shifted_d = mif.bus_rdata >> {lane_q, 3'b000};
        rdata_d   = shifted_d;
        case (size_q)
            SZ_BYTE: rdata_d = uns_q ? {24'h000000, shifted_d[7:0]}
                                     : {{24{shifted_d[7]}}, shifted_d[7:0]};
            SZ_HALF: rdata_d = uns_q ? {16'h0000, shifted_d[15:0]}
                                     : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: rdata_d = shifted_d;
        endcase
    end

    // Write-back mask: narrow only for zero-extended byte/half loads
    always_comb begin
        mask_d = 32'hFFFF_FFFF;
        case (size_q)
            SZ_BYTE: mask_d = uns_q ? 32'h0000_00FF : 32'hFFFF_FFFF;
            SZ_HALF: mask_d = uns_q ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            default: mask_d = 32'hFFFF_FFFF;
        endcase
    end

    // Access FSM with registered bus and write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            lane_q       <= 2'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0000_0000;
            bus_wdata_q  <= 32'h0000_0000;
            bus_wstrb_q  <= 4'b0000;
            read_data_q  <= 32'h0000_0000;
            read_valid_q <= 1'b0;
            wb_mask_q    <= 32'h0000_0000;
            fault_q      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q    <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mif.req_valid) begin
                        we_q   <= mif.req_we;
                        size_q <= mif.req_size;
                        uns_q  <= mif.req_unsigned;
                        lane_q <= mif.req_addr[1:0];
                        if (misaligned_d) begin
                            // Abort without touching the bus
                            state_q      <= ST_DONE;
                            fault_q      <= 1'b1;
                            read_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_BUS;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mif.req_we;
                            bus_addr_q  <= {mif.req_addr[31:2], 2'b00};
                            bus_wdata_q <= wdata_d;
                            bus_wstrb_q <= wstrb_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            tmo_cnt_q   <= 8'd0;
`endif
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    // Bus outputs stay frozen until acknowledged
                    if (mif.bus_ack) begin
                        state_q      <= ST_DONE;
                        bus_req_q    <= 1'b0;
                        read_data_q  <= rdata_d;
                        wb_mask_q    <= mask_d;
                        read_valid_q <= ~we_q;
                        fault_q      <= 1'b0;
                    end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                        if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
                            state_q      <= ST_DONE;
                            bus_req_q    <= 1'b0;
                            read_valid_q <= 1'b0;
                            fault_q      <= 1'b1;
                            tmo_cnt_q    <= tmo_cnt_q + 8'd1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        end
`else
                        state_q <= ST_BUS;
`endif
                    end
                end
                ST_DONE: begin
                    // Single completion cycle; new requests wait for IDLE
                    state_q      <= ST_IDLE;
                    read_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    bus_req_q    <= 1'b0;
                    read_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                end
            endcase
        end
    end

    // Stall must react in the request cycle itself, so it is decoded from state
    assign mif.mem_stall  = ~rst & (((state_q == ST_IDLE) & mif.req_valid) |
                                    (state_q == ST_BUS));
    assign mif.bus_req    = bus_req_q;
    assign mif.bus_we     = bus_we_q;
    assign mif.bus_addr   = bus_addr_q;
    assign mif.bus_wdata  = bus_wdata_q;
    assign mif.bus_wstrb  = bus_wstrb_q;
    assign mif.read_data  = read_data_q;
    assign mif.read_valid = read_valid_q;
    assign mif.wb_mask    = wb_mask_q;
    assign mif.fault      = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. Inputs change on the falling edge
// and outputs are sampled 1 ns later.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_access_ctrl_if mif();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    always #5 clk = ~clk;

    // Results captured by run_access
    int          r_stall;
    logic [31:0] r_rd, r_mask, r_baddr, r_bwdata;
    logic [3:0]  r_bwstrb;
    logic        r_rv, r_flt, r_bwe, r_breq, r_stable, r_breq0;

    // Drives one access: request cycle, waits+1 BUS cycles (ack on the last),
    // then the DONE cycle. waits = -1 means no BUS phase is expected.
    task automatic run_access(input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int waits, input logic next_valid);
        @(negedge clk);
        mif.req_valid = 1'b1; mif.req_we = we; mif.req_size = size;
        mif.req_unsigned = uns; mif.req_addr = addr; mif.req_wdata = wdata;
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;
        #1;
        r_stall = int'(mif.mem_stall);
        r_breq0 = mif.bus_req;
        r_breq = 1'b0; r_stable = 1'b1;
        r_baddr = 32'h0; r_bwdata = 32'h0; r_bwstrb = 4'h0; r_bwe = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            mif.bus_ack   = (i == waits);
            mif.bus_rdata = (i == waits) ? rdata : 32'hDEAD_BEEF;
            #1;
            r_stall += int'(mif.mem_stall);
            r_breq  |= mif.bus_req;
            if (i == 0) begin
                r_baddr = mif.bus_addr; r_bwdata = mif.bus_wdata;
                r_bwstrb = mif.bus_wstrb; r_bwe = mif.bus_we;
            end else if (mif.bus_addr !== r_baddr || mif.bus_wdata !== r_bwdata ||
                         mif.bus_wstrb !== r_bwstrb || mif.bus_we !== r_bwe ||
                         mif.bus_req !== 1'b1) begin
                r_stable = 1'b0;
            end
        end
        @(negedge clk);
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;
        mif.req_valid = next_valid;
        #1;
        r_stall += int'(mif.mem_stall);
        r_rd = mif.read_data; r_mask = mif.wb_mask;
        r_rv = mif.read_valid; r_flt = mif.fault;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_size = 2'd2;
        mif.req_unsigned = 1'b0; mif.req_addr = 32'h100; mif.req_wdata = 32'h0;
        mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (mif.mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", mif.mem_stall); end
        n_cmp++; if ({mif.bus_req, mif.bus_we, mif.read_valid, mif.fault} !== 4'b0000) begin n_bad++;
            $display("FAIL rst_ctrl: got req/we/rv/flt=%b want 0000", {mif.bus_req, mif.bus_we, mif.read_valid, mif.fault}); end
        n_cmp++; if ({mif.bus_addr, mif.bus_wdata, mif.bus_wstrb} !== 68'h0) begin n_bad++;
            $display("FAIL rst_bus: got addr=%h wdata=%h wstrb=%h want 0", mif.bus_addr, mif.bus_wdata, mif.bus_wstrb); end
        n_cmp++; if ({mif.read_data, mif.wb_mask} !== 64'h0) begin n_bad++;
            $display("FAIL rst_wb: got rd=%h mask=%h want 0", mif.read_data, mif.wb_mask); end
        @(negedge clk);
        rst = 1'b0; mif.req_valid = 1'b0;
    endtask

    task automatic test_lw();
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8765_4321, 0, 1'b0);
        n_cmp++; if (r_breq0 !== 1'b0) begin n_bad++; $display("FAIL lw_req_c0: got %b want 0", r_breq0); end
        n_cmp++; if (r_stall != 2) begin n_bad++; $display("FAIL lw_stall: got %0d want 2", r_stall); end
        n_cmp++; if (r_baddr !== 32'h100 || r_bwstrb !== 4'h0 || r_bwe !== 1'b0) begin n_bad++;
            $display("FAIL lw_bus: got addr=%h wstrb=%h we=%b want 100/0/0", r_baddr, r_bwstrb, r_bwe); end
        n_cmp++; if (r_rv !== 1'b1 || r_flt !== 1'b0) begin n_bad++; $display("FAIL lw_rv: got rv=%b flt=%b want 1/0", r_rv, r_flt); end
        n_cmp++; if (r_rd !== 32'h8765_4321) begin n_bad++; $display("FAIL lw_rdata: got %h want 87654321", r_rd); end
        n_cmp++; if (r_mask !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL lw_mask: got %h want ffffffff", r_mask); end
        @(negedge clk); #1;
        n_cmp++; if (mif.read_valid !== 1'b0 || mif.read_data !== 32'h8765_4321) begin n_bad++;
            $display("FAIL lw_after: got rv=%b rd=%h want 0/87654321", mif.read_valid, mif.read_data); end
    endtask

    task automatic test_loads_ext();
        run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 3, 1'b0);
        n_cmp++; if (r_stall != 5) begin n_bad++; $display("FAIL lb_stall: got %0d want 5", r_stall); end
        n_cmp++; if (r_stable !== 1'b1 || r_baddr !== 32'h100) begin n_bad++;
            $display("FAIL lb_bus_stable: got stable=%b addr=%h want 1/100", r_stable, r_baddr); end
        n_cmp++; if (r_rd !== 32'hFFFF_FF80 || r_mask !== 32'hFFFF_FFFF) begin n_bad++;
            $display("FAIL lb_data: got rd=%h mask=%h want ffffff80/ffffffff", r_rd, r_mask); end
        run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0, 1'b0);
        n_cmp++; if (r_rd !== 32'h0000_0080 || r_mask !== 32'h0000_00FF || r_rv !== 1'b1) begin n_bad++;
            $display("FAIL lbu_data: got rd=%h mask=%h rv=%b want 00000080/000000ff/1", r_rd, r_mask, r_rv); end
        run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 1, 1'b0);
        n_cmp++; if (r_rd !== 32'hFFFF_8001 || r_mask !== 32'hFFFF_FFFF) begin n_bad++;
            $display("FAIL lh_data: got rd=%h mask=%h want ffff8001/ffffffff", r_rd, r_mask); end
        run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 0, 1'b0);
        n_cmp++; if (r_rd !== 32'h0000_8001 || r_mask !== 32'h0000_FFFF) begin n_bad++;
            $display("FAIL lhu_data: got rd=%h mask=%h want 00008001/0000ffff", r_rd, r_mask); end
        run_access(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 32'h1234_7F00, 0, 1'b0);
        n_cmp++; if (r_rd !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_pos: got %h want 0000007f", r_rd); end
    endtask

    task automatic test_stores();
        run_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1'b0);
        n_cmp++; if (r_bwe !== 1'b1 || r_bwdata !== 32'hBEEF_BEEF) begin n_bad++;
            $display("FAIL sh_wdata: got we=%b wdata=%h want 1/beefbeef", r_bwe, r_bwdata); end
        n_cmp++; if (r_bwstrb !== 4'b1100 || r_baddr !== 32'h100) begin n_bad++;
            $display("FAIL sh_strb: got wstrb=%b addr=%h want 1100/100", r_bwstrb, r_baddr); end
        n_cmp++; if (r_rv !== 1'b0 || r_flt !== 1'b0) begin n_bad++; $display("FAIL sh_rv: got rv=%b flt=%b want 0/0", r_rv, r_flt); end
        run_access(1'b1, 2'd0, 1'b0, 32'h101, 32'h1234_56AB, 32'h0, 2, 1'b0);
        n_cmp++; if (r_bwdata !== 32'hABAB_ABAB || r_bwstrb !== 4'b0010 || r_stable !== 1'b1) begin n_bad++;
            $display("FAIL sb: got wdata=%h wstrb=%b stable=%b want abababab/0010/1", r_bwdata, r_bwstrb, r_stable); end
        run_access(1'b1, 2'd2, 1'b0, 32'h204, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        n_cmp++; if (r_bwdata !== 32'hCAFE_F00D || r_bwstrb !== 4'hF || r_baddr !== 32'h204) begin n_bad++;
            $display("FAIL sw: got wdata=%h wstrb=%h addr=%h want cafef00d/f/204", r_bwdata, r_bwstrb, r_baddr); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, -1, 1'b0);
        n_cmp++; if (r_breq0 !== 1'b0 || r_stall != 1) begin n_bad++;
            $display("FAIL lw_mis_nobus: got req=%b stall=%0d want 0/1", r_breq0, r_stall); end
        n_cmp++; if (r_flt !== 1'b1 || r_rv !== 1'b0 || mif.mem_stall !== 1'b0 || mif.bus_req !== 1'b0) begin n_bad++;
            $display("FAIL lw_mis_fault: got flt=%b rv=%b stall=%b req=%b want 1/0/0/0", r_flt, r_rv, mif.mem_stall, mif.bus_req); end
        @(negedge clk); #1;
        n_cmp++; if (mif.fault !== 1'b0) begin n_bad++; $display("FAIL mis_clear: got %b want 0", mif.fault); end
        run_access(1'b1, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0, -1, 1'b0);
        n_cmp++; if (r_flt !== 1'b1 || mif.bus_req !== 1'b0) begin n_bad++;
            $display("FAIL sh_mis: got flt=%b req=%b want 1/0", r_flt, mif.bus_req); end
        run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, -1, 1'b0);
        n_cmp++; if (r_flt !== 1'b1 || r_rv !== 1'b0) begin n_bad++;
            $display("FAIL size3: got flt=%b rv=%b want 1/0", r_flt, r_rv); end
    endtask

    task automatic test_back_to_back();
        // Next instruction already presented in DONE; it must wait for IDLE
        run_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 0, 1'b1);
        n_cmp++; if (r_stall != 2 || r_rd !== 32'h1111_2222) begin n_bad++;
            $display("FAIL b2b_first: got stall=%0d rd=%h want 2/11112222", r_stall, r_rd); end
        run_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h3333_4444, 0, 1'b0);
        n_cmp++; if (r_breq0 !== 1'b0 || r_rd !== 32'h3333_4444 || r_rv !== 1'b1 || r_baddr !== 32'h304) begin n_bad++;
            $display("FAIL b2b_second: got req0=%b rd=%h rv=%b addr=%h want 0/33334444/1/304", r_breq0, r_rd, r_rv, r_baddr); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_size = 2'd2;
        mif.req_unsigned = 1'b0; mif.req_addr = 32'h400; mif.bus_ack = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (mif.bus_req !== 1'b1) begin n_bad++; $display("FAIL rm_busreq: got %b want 1", mif.bus_req); end
        rst = 1'b1; #1;
        n_cmp++; if (mif.mem_stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall_in_rst: got %b want 0", mif.mem_stall); end
        @(negedge clk);
        rst = 1'b0; mif.req_valid = 1'b0; mif.bus_ack = 1'b1; mif.bus_rdata = 32'h5555_AAAA;
        #1;
        n_cmp++; if (mif.bus_req !== 1'b0 || mif.mem_stall !== 1'b0) begin n_bad++;
            $display("FAIL rm_abandon: got req=%b stall=%b want 0/0", mif.bus_req, mif.mem_stall); end
        @(negedge clk);
        mif.bus_ack = 1'b0; #1;
        n_cmp++; if (mif.read_valid !== 1'b0 || mif.fault !== 1'b0 || mif.bus_req !== 1'b0) begin n_bad++;
            $display("FAIL rm_late_ack: got rv=%b flt=%b req=%b want 0/0/0", mif.read_valid, mif.fault, mif.bus_req); end
    endtask

    task automatic test_no_ack();
        int bus_cnt;
        logic hit;
        bus_cnt = 0; hit = 1'b0;
        @(negedge clk);
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_size = 2'd2;
        mif.req_unsigned = 1'b0; mif.req_addr = 32'h500; mif.bus_ack = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mif.fault === 1'b1) begin hit = 1'b1; break; end
            if (mif.bus_req === 1'b1) bus_cnt++;
        end
        n_cmp++; if (hit !== 1'b1 || bus_cnt != 4) begin n_bad++;
            $display("FAIL tmo_fault: got hit=%b bus_cycles=%0d want 1/4", hit, bus_cnt); end
        n_cmp++; if (mif.bus_req !== 1'b0 || mif.read_valid !== 1'b0 || mif.mem_stall !== 1'b0) begin n_bad++;
            $display("FAIL tmo_outputs: got req=%b rv=%b stall=%b want 0/0/0", mif.bus_req, mif.read_valid, mif.mem_stall); end
        mif.req_valid = 1'b0;
        @(negedge clk);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (mif.mem_stall !== 1'b1 || mif.bus_req !== 1'b1 || mif.fault !== 1'b0) bus_cnt++;
        end
        n_cmp++; if (bus_cnt != 0) begin n_bad++;
            $display("FAIL noack_hold: got %0d bad cycles want 0", bus_cnt); end
        hit = 1'b1;
        rst = 1'b1; mif.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++; if (mif.bus_req !== 1'b0 || mif.mem_stall !== 1'b0) begin n_bad++;
            $display("FAIL noack_rst: got req=%b stall=%b want 0/0", mif.bus_req, mif.mem_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads_ext();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_no_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
